// File: rtl/pipearch_common_pkg.sv
// pipearch_common: shared CSR write record, instruction layout and collector output states.
package pipearch_common;
    localparam int CSR_DATA_WIDTH  = 64;
    localparam int NUM_INSTR_WORDS = 4;
    // opcode lives in the low bits of the commit word (word NUM_INSTR_WORDS-1)
    localparam int OPCODE_LSB      = 0;
    localparam int OPCODE_WIDTH    = 8;

    typedef struct packed {
        logic                      en;
        logic [CSR_DATA_WIDTH-1:0] data;
    } t_cpu_wr_csrs;

    typedef logic [NUM_INSTR_WORDS-1:0][CSR_DATA_WIDTH-1:0] t_instruction;

    typedef enum logic {EMPTY, VALID} t_out_state;
endpackage

// File: rtl/instr_sync_fifo.sv
// instr_sync_fifo: synchronous FIFO with separate occupancy counter; head reads as zero when empty.
module instr_sync_fifo #(
    parameter int WIDTH      = 256,
    parameter int LOG2_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic [LOG2_DEPTH:0]   count,
    output logic                  full
);
    localparam int DEPTH = 1 << LOG2_DEPTH;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LOG2_DEPTH:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + LOG2_DEPTH'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + LOG2_DEPTH'(1) : rd_ptr_q;
        count_d  = count_q + (LOG2_DEPTH+1)'(push) - (LOG2_DEPTH+1)'(pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count = count_q;
    assign full  = count_q[LOG2_DEPTH];
endmodule

// File: rtl/csr_instruction_collector.sv
// csr_instruction_collector: stages CSR payload writes, commits on the last index into a FIFO,
// and tracks dropped commits.
module csr_instruction_collector
    import pipearch_common::*;
#(
    parameter int NUM_WORDS      = NUM_INSTR_WORDS,
    parameter int DATA_WIDTH     = CSR_DATA_WIDTH,
    parameter int LOG2_DEPTH     = 4,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  t_cpu_wr_csrs [NUM_WORDS-1:0]    wr_csrs,
    input  logic                            clear_status,
    output logic                            instr_valid,
    output logic [NUM_WORDS*DATA_WIDTH-1:0] instr_data,
    input  logic                            instr_ready,
    output logic [LOG2_DEPTH:0]             fifo_count,
    output logic                            overflow,
    output logic [DROP_CNT_WIDTH-1:0]       drop_count
);
    logic [NUM_WORDS-2:0][DATA_WIDTH-1:0] stage_q, stage_d;
    logic [NUM_WORDS*DATA_WIDTH-1:0]      commit_data;
    logic [DROP_CNT_WIDTH-1:0]            drop_count_q, drop_count_d;
    logic                                 overflow_q, overflow_d;
    t_out_state                           state_q, state_d;
    logic                                 commit, push, pop, drop, full;

    // same-cycle payload writes flow straight into the committed instruction
    always_comb begin
        stage_d = stage_q;
        for (int i = 0; i < NUM_WORDS-1; i++)
            if (wr_csrs[i].en) stage_d[i] = wr_csrs[i].data[DATA_WIDTH-1:0];
    end

    assign commit      = wr_csrs[NUM_WORDS-1].en;
    assign commit_data = {wr_csrs[NUM_WORDS-1].data[DATA_WIDTH-1:0], stage_d};
    assign pop         = (state_q == VALID) && instr_ready;
    assign push        = commit && (!full || pop);
    assign drop        = commit && !push;

    always_comb begin
        state_d = state_q;
        if (state_q == EMPTY && push)
            state_d = VALID;
        else if (state_q == VALID && pop && !push && fifo_count == (LOG2_DEPTH+1)'(1))
            state_d = EMPTY;
    end

    // clear applies first so a simultaneous drop still leaves a count of one
    always_comb begin
        overflow_d   = drop | (overflow_q & ~clear_status);
        drop_count_d = clear_status ? DROP_CNT_WIDTH'(drop)
                     : (drop && drop_count_q != '1) ? drop_count_q + DROP_CNT_WIDTH'(1)
                     : drop_count_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
            state_q      <= EMPTY;
        end else begin
            stage_q      <= stage_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
            state_q      <= state_d;
        end
    end

    instr_sync_fifo #(
        .WIDTH      (NUM_WORDS*DATA_WIDTH),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (commit_data),
        .pop       (pop),
        .head      (instr_data),
        .count     (fifo_count),
        .full      (full)
    );

    assign instr_valid = (state_q == VALID);
    assign overflow    = overflow_q;
    assign drop_count  = drop_count_q;
endmodule

// File: tb/tb_csr_instruction_collector.sv
// tb_csr_instruction_collector: directed and random stimulus against a queue-based model of the collector.
module tb_csr_instruction_collector;
    import pipearch_common::*;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  clear_status = 1'b0;
    logic                  instr_ready = 1'b0;
    t_cpu_wr_csrs [3:0]    wr_csrs;
    logic                  instr_valid;
    logic [255:0]          instr_data;
    logic [4:0]            fifo_count;
    logic                  overflow;
    logic [15:0]           drop_count;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [255:0] mq[$];
    logic [63:0]  mstage[3];
    logic         m_ovf;
    logic [15:0]  m_dc;

    csr_instruction_collector dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_csrs      (wr_csrs),
        .clear_status (clear_status),
        .instr_valid  (instr_valid),
        .instr_data   (instr_data),
        .instr_ready  (instr_ready),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_valid"}, instr_valid, mq.size() != 0);
        check({tag, "_count"}, fifo_count, mq.size());
        if (mq.size() != 0) check({tag, "_data"}, instr_data, mq[0]);
        check({tag, "_ovf"}, overflow, m_ovf);
        check({tag, "_dc"}, drop_count, m_dc);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // d = {w3, w2, w1, w0}; called at a negedge, returns at the next negedge
    task automatic cyc(input string tag, input logic [3:0] en, input logic [255:0] d,
                       input logic rdy, input logic clr);
        logic pop;
        for (int i = 0; i < 4; i++) begin
            wr_csrs[i].en   = en[i];
            wr_csrs[i].data = d[i*64 +: 64];
        end
        instr_ready  = rdy;
        clear_status = clr;
        pop = rdy && mq.size() != 0;
        for (int i = 0; i < 3; i++) if (en[i]) mstage[i] = d[i*64 +: 64];
        if (clr) begin
            m_ovf = 1'b0;
            m_dc  = '0;
        end
        if (pop) void'(mq.pop_front());
        if (en[3]) begin
            if (mq.size() < 16) mq.push_back({d[255:192], mstage[2], mstage[1], mstage[0]});
            else begin
                m_ovf = 1'b1;
                if (m_dc != 16'hFFFF) m_dc++;
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
        @(negedge clk);
        wr_csrs      = '0;
        instr_ready  = 1'b0;
        clear_status = 1'b0;
    endtask

    task automatic commit_rnd(input string tag, input logic rdy);
        cyc(tag, 4'b1111, {rnd64(), rnd64(), rnd64(), rnd64()}, rdy, 1'b0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && mq.size() != 0; i++) cyc(tag, 4'b0000, '0, 1'b1, 1'b0);
        check({tag, "_empty"}, fifo_count, 0);
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 3; i++) mstage[i] = '0;
        m_ovf = 1'b0;
        m_dc  = '0;
    endtask

    initial begin
        wr_csrs = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_valid", instr_valid, 0);
        check("rst_data", instr_data, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_dc", drop_count, 0);
        reset_n = 1'b1;
        @(negedge clk);

        cyc("tp1_w0", 4'b0001, {192'h0, 64'h11}, 1'b0, 1'b0);
        cyc("tp1_w1", 4'b0010, {128'h0, 64'h22, 64'h0}, 1'b0, 1'b0);
        cyc("tp1_w2", 4'b0100, {64'h0, 64'h33, 128'h0}, 1'b0, 1'b0);
        cyc("tp1_commit", 4'b1000, {64'hA0, 192'h0}, 1'b1, 1'b0);
        check("tp1_valid", instr_valid, 1);
        check("tp1_data", instr_data, {64'hA0, 64'h33, 64'h22, 64'h11});
        cyc("tp1_pop", 4'b0000, '0, 1'b1, 1'b0);
        check("tp1_count", fifo_count, 0);

        cyc("tp2_bypass", 4'b1010, {64'hB1, 64'h0, 64'h55, 64'h0}, 1'b0, 1'b0);
        check("tp2_data", instr_data, {64'hB1, 64'h33, 64'h55, 64'h11});
        drain("tp2_drain");

        for (int i = 0; i < 17; i++) commit_rnd("tp3_fill", 1'b0);
        check("tp3_count", fifo_count, 16);
        check("tp3_ovf", overflow, 1);
        check("tp3_dc", drop_count, 1);
        drain("tp3_drain");

        cyc("clr_alone", 4'b0000, '0, 1'b0, 1'b1);
        check("clr_alone_dc", drop_count, 0);
        for (int i = 0; i < 16; i++) commit_rnd("tp4_fill", 1'b0);
        for (int i = 0; i < 40; i++) commit_rnd("tp4_wrap", 1'b1);
        check("tp4_count", fifo_count, 16);
        check("tp4_dc", drop_count, 0);

        for (int i = 0; i < 5; i++) commit_rnd("tp5_drop", 1'b0);
        check("tp5_dc5", drop_count, 5);
        cyc("tp5_clr_drop", 4'b1000, {rnd64(), 192'h0}, 1'b0, 1'b1);
        check("tp5_ovf", overflow, 1);
        check("tp5_dc", drop_count, 1);
        cyc("tp5_clr", 4'b0000, '0, 1'b0, 1'b1);
        check("tp5_ovf_clr", overflow, 0);
        check("tp5_dc_clr", drop_count, 0);
        drain("tp5_drain");

        for (int i = 0; i < 7; i++) commit_rnd("tp6_fill", 1'b0);
        check("tp6_count7", fifo_count, 7);
        reset_n = 1'b0;
        #1;
        check("tp6_valid", instr_valid, 0);
        check("tp6_count", fifo_count, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        cyc("tp6_commit", 4'b1000, {64'hC7, 192'h0}, 1'b0, 1'b0);
        check("tp6_data", instr_data, {64'hC7, 192'h0});
        drain("tp6_drain");

        for (int i = 0; i < 400; i++)
            cyc("rnd", 4'($urandom), {rnd64(), rnd64(), rnd64(), rnd64()},
                1'($urandom_range(0, 2) != 0 ? 0 : 1) | 1'($urandom_range(0, 1)),
                $urandom_range(0, 15) == 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
